// File: rtl/arm_cpu_pkg.sv
// Shared CPU constants: register-index width, datapath width and the XZR index.
// Imported by the register file and its read-port slices.
package arm_cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 64;

  localparam logic [REG_ADDR_W-1:0] XZR_INDEX = 5'd31;

  // Number of physical registers: every index except XZR has storage.
  localparam int NUM_STORED_REGS = (1 << REG_ADDR_W) - 1;

endpackage : arm_cpu_pkg

// File: rtl/register_file_read_port.sv
// One read port of the LEGv8 register file: XZR zeroing plus the optional WB->ID bypass.
// The bypass is compiled in only when REGFILE_BYPASS_EN is defined.
module register_file_read_port
  import arm_cpu_pkg::*;
#(
  parameter int n      = DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic [ADDR_W-1:0] read_index,
  input  logic [n-1:0]      array_word,
  input  logic [ADDR_W-1:0] write_index,
  input  logic [n-1:0]      write_data,
  input  logic              write_enable,
  input  logic              reset,
  output logic [n-1:0]      read_data
);

  localparam logic [ADDR_W-1:0] ZR_INDEX = ADDR_W'(XZR_INDEX);

  logic is_zr;
  assign is_zr = (read_index == ZR_INDEX);

`ifdef REGFILE_BYPASS_EN
  // A write in flight to this index is forwarded. Reset suppresses it so that the
  // stored array stays visible until the clearing edge.
  logic bypass_hit;
  assign bypass_hit = write_enable && !reset && (write_index == read_index) && !is_zr;

  always_comb begin
    read_data = array_word;
    if (is_zr) begin
      read_data = '0;
    end else if (bypass_hit) begin
      read_data = write_data;
    end
  end
`else
  logic unused_write_side;
  assign unused_write_side = ^{write_index, write_data, write_enable, reset};

  always_comb begin
    read_data = array_word;
    if (is_zr) begin
      read_data = '0;
    end
  end
`endif

endmodule : register_file_read_port

// File: rtl/register_file.sv
// LEGv8 register file: 31 stored registers plus XZR, two async read ports, one sync write port.
// Define REGFILE_BYPASS_EN to forward a same-cycle write to the read ports.
module register_file
  import arm_cpu_pkg::*;
#(
  parameter int n      = DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              input_clk,
  input  logic              input_reset,
  input  logic [ADDR_W-1:0] input_read_register_1,
  input  logic [ADDR_W-1:0] input_read_register_2,
  input  logic [ADDR_W-1:0] input_write_register,
  input  logic [n-1:0]      input_write_data,
  input  logic              input_reg_write,
  output logic [n-1:0]      output_read_data_1,
  output logic [n-1:0]      output_read_data_2
);

  localparam int NUM_INDICES = 1 << ADDR_W;
  localparam int NUM_ENTRIES = NUM_INDICES - 1;
  localparam logic [ADDR_W-1:0] ZR_INDEX = ADDR_W'(XZR_INDEX);

  // The initialiser keeps the read outputs defined before the first reset in simulation.
  logic [n-1:0] regs_reg [0:NUM_ENTRIES-1] = '{default: '0};

  logic write_accept;
  assign write_accept = input_reg_write && (input_write_register != ZR_INDEX);

  always_ff @(posedge input_clk) begin
    if (input_reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (write_accept) begin
      regs_reg[input_write_register] <= input_write_data;
    end
  end

  // Full-range view so every index decodes to a word; XZR has no storage behind it.
  logic [n-1:0] read_view [0:NUM_INDICES-1];

  generate
    for (genvar gi = 0; gi < NUM_INDICES; gi++) begin : g_view
      if (gi == NUM_ENTRIES) begin : g_zr
        assign read_view[gi] = '0;
      end else begin : g_reg
        assign read_view[gi] = regs_reg[gi];
      end
    end
  endgenerate

  logic [n-1:0] array_word_1;
  logic [n-1:0] array_word_2;
  assign array_word_1 = read_view[input_read_register_1];
  assign array_word_2 = read_view[input_read_register_2];

  register_file_read_port #(
    .n      (n),
    .ADDR_W (ADDR_W)
  ) u_read_port_1 (
    .read_index   (input_read_register_1),
    .array_word   (array_word_1),
    .write_index  (input_write_register),
    .write_data   (input_write_data),
    .write_enable (input_reg_write),
    .reset        (input_reset),
    .read_data    (output_read_data_1)
  );

  register_file_read_port #(
    .n      (n),
    .ADDR_W (ADDR_W)
  ) u_read_port_2 (
    .read_index   (input_read_register_2),
    .array_word   (array_word_2),
    .write_index  (input_write_register),
    .write_data   (input_write_data),
    .write_enable (input_reg_write),
    .reset        (input_reset),
    .read_data    (output_read_data_2)
  );

endmodule : register_file

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected read data, a negedge monitor compares.
module tb_register_file;

  localparam logic [63:0] V5   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] VALL = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] V30  = 64'hA5A5_0000_1111_3030;
  localparam logic [63:0] V0   = 64'h8000_0000_0000_0001;

  logic        clk;
  logic        rst;
  logic [4:0]  rd1;
  logic [4:0]  rd2;
  logic [4:0]  wr;
  logic [63:0] wd;
  logic        we;
  logic [63:0] q1;
  logic [63:0] q2;

  typedef struct {
    string       name;
    logic [63:0] e1;
    logic [63:0] e2;
  } exp_t;

  exp_t exp_q[$];
  logic chk_valid;
  int   checks;
  int   failures;

  register_file dut (
    .input_clk             (clk),
    .input_reset           (rst),
    .input_read_register_1 (rd1),
    .input_read_register_2 (rd2),
    .input_write_register  (wr),
    .input_write_data      (wd),
    .input_reg_write       (we),
    .output_read_data_1    (q1),
    .output_read_data_2    (q2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected entry per flagged cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow got=empty required=entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks += 2;
        if (q1 !== e.e1) begin
          failures++;
          $display("FAIL %s port1 got=%h required=%h", e.name, q1, e.e1);
        end
        if (q2 !== e.e2) begin
          failures++;
          $display("FAIL %s port2 got=%h required=%h", e.name, q2, e.e2);
        end
        $display("check %s p1=%h p2=%h", e.name, q1, q2);
      end
    end
  end

  task automatic drive(input logic r, input logic w, input logic [4:0] wi,
                       input logic [63:0] d, input logic [4:0] a1, input logic [4:0] a2);
    rst = r; we = w; wr = wi; wd = d; rd1 = a1; rd2 = a2;
  endtask

  task automatic expect_rd(input string name, input logic [63:0] e1, input logic [63:0] e2);
    exp_t e;
    e.name = name; e.e1 = e1; e.e2 = e2;
    exp_q.push_back(e);
    chk_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk_valid = 1'b0;
  endtask

  logic bypass;

  initial begin
    checks = 0;
    failures = 0;
    chk_valid = 1'b0;
`ifdef REGFILE_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd31);
    @(posedge clk);
    #1;

    // Outputs defined before any reset
    expect_rd("pre_reset", 64'd0, 64'd0);
    tick();

    // Test 1: reset then sweep all indices on both ports
    drive(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    tick();
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i));
      expect_rd($sformatf("reset_sweep_%0d", i), 64'd0, 64'd0);
      tick();
    end

    // Test 2: write X5, same cycle shows bypass or old value, next cycle the new value
    drive(1'b0, 1'b1, 5'd5, V5, 5'd5, 5'd0);
    expect_rd("x5_write_cycle", bypass ? V5 : 64'd0, 64'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd5, 5'd5);
    expect_rd("x5_read_both", V5, V5);
    tick();

    // Test 3: XZR ignores writes and never bypasses
    drive(1'b0, 1'b1, 5'd31, VALL, 5'd31, 5'd31);
    expect_rd("xzr_write_cycle", 64'd0, 64'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd31, 5'd31);
    expect_rd("xzr_after", 64'd0, 64'd0);
    tick();

    // Test 4: same-cycle read/write of X7
    drive(1'b0, 1'b1, 5'd7, 64'd10, 5'd5, 5'd7);
    expect_rd("x7_load10", V5, bypass ? 64'd10 : 64'd0);
    tick();
    drive(1'b0, 1'b1, 5'd7, 64'd20, 5'd5, 5'd7);
    expect_rd("x7_same_cycle", V5, bypass ? 64'd20 : 64'd10);
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd5, 5'd7);
    expect_rd("x7_after_edge", V5, 64'd20);
    tick();

    // Test 5: reset wins over a same-edge write; no bypass while reset is high
    drive(1'b0, 1'b1, 5'd3, 64'd42, 5'd3, 5'd7);
    expect_rd("x3_load42", bypass ? 64'd42 : 64'd0, 64'd20);
    tick();
    drive(1'b1, 1'b1, 5'd3, 64'd99, 5'd3, 5'd7);
    expect_rd("reset_with_write", 64'd42, 64'd20);
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd3, 5'd7);
    expect_rd("after_reset_x3", 64'd0, 64'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd5, 5'd5);
    expect_rd("after_reset_x5", 64'd0, 64'd0);
    tick();

    // Test 6: boundary indices X30 and X0, no aliasing, no extension
    drive(1'b0, 1'b1, 5'd30, V30, 5'd30, 5'd0);
    expect_rd("x30_write_cycle", bypass ? V30 : 64'd0, 64'd0);
    tick();
    drive(1'b0, 1'b1, 5'd0, V0, 5'd0, 5'd30);
    expect_rd("x0_write_cycle", bypass ? V0 : 64'd0, V30);
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd30);
    expect_rd("x0_x30_read", V0, V30);
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd30, 5'd0);
    expect_rd("x30_x0_swap", V30, V0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd1, 5'd31);
    expect_rd("x1_x31_untouched", 64'd0, 64'd0);
    tick();

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_register_file
